keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner for the vending front panel. It handles ROWS x COLS keys, synchronises and debounces the row inputs, and rejects multi-key presses. Each accepted keypress is reported as one linear key code over a valid/ready handshake to the vending controller.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column drive outputs (2..8)
SCAN_DIV, 16, clock cycles each column is driven before row sampling (>=4)
DEBOUNCE, 3, consecutive matching samples required to accept a press or a release (>=1)
CODE_W, clog2(ROWS*COLS), key code width (derived, not overridden)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
row_in  in  ROWS  raw row sense lines, active-high, asynchronous to clock
col_out  out  COLS  column drive, one-hot during scan, all-ones in IDLE/RELEASE
code  out  CODE_W  key code = row_index*COLS + col_index
valid  out  1  code available; held until accepted
ready  in  1  consumer accepts code when valid&&ready
multi_err  out  1  one-cycle pulse: multi-key press rejected
busy  out  1  high in every state except IDLE

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- Reset values: state=IDLE, col_out=all-ones, code=0, valid=0, multi_err=0, busy=0, all counters=0.
- row_in passes through a 2-flop synchroniser (row_s). All decisions use row_s.
- Dwell counter: counts 0..SCAN_DIV-1 in SCAN, DEBOUNCE and RELEASE. A "sample" is taken at count==SCAN_DIV-1, then the counter wraps to 0.
- IDLE: col_out=all-ones. If row_s!=0, go to SCAN with column 0 and the counter cleared.
- SCAN: col_out=one-hot(col_idx). At each sample:
  - row_s zero: col_idx++.
  - row_s one-hot: latch row_idx and col_idx, go to DEBOUNCE with match count 1.
  - row_s has more than one bit set: pulse multi_err, go to RELEASE.
  - col_idx wraps past COLS-1 with no hit: return to IDLE (glitch), no report.
- Column priority: the lowest column index wins.
- DEBOUNCE: col_out stays on the latched column. At each sample:
  - row_s equals the latched one-hot row: match count++.
  - row_s zero: return to IDLE, no report.
  - row_s is any other non-zero value: pulse multi_err, go to RELEASE.
  - match count reaches DEBOUNCE: register code, set valid, go to REPORT.
- REPORT: col_out=all-ones.
  - valid and code are held stable while ready=0.
  - On valid&&ready: valid clears on the next edge and the state goes to RELEASE.
  - No new key is accepted while valid is pending.
- RELEASE: col_out=all-ones. Wait for DEBOUNCE consecutive samples with row_s==0, then go to IDLE. Any non-zero sample resets the release count. No auto-repeat: a held key is never re-reported.
- Press latency from a stable key to valid: 2 (sync) + (col_idx+1)*SCAN_DIV + (DEBOUNCE-1)*SCAN_DIV + 1 cycles, give or take the IDLE-detect cycle. The bench checks the window ±SCAN_DIV.
- code arithmetic: row_idx*COLS+col_idx computed at CODE_W bits, no overflow by construction. Unused codes cannot occur.
- multi_err is exactly one cycle wide and is never asserted together with a valid rising edge.
- Reset mid-operation: all state returns to reset values immediately (async). A pending valid is dropped.
- ready asserted while valid=0 is ignored.

Decomposition:
- Package keypad_pkg holds:
  - the state enum {IDLE, SCAN, DEBOUNCE, REPORT, RELEASE};
  - a clog2-based width helper;
  - a onehot/popcount helper function used for the multi-key check.
- One natural sub-module: row_sync, a ROWS-wide 2-flop synchroniser with async reset to 0.
- The FSM, counters and output register stay in keypad_scanner.

Test Plan:
- Default 4x4 config, SCAN_DIV=4, DEBOUNCE=2: hold row_in=4'b0100 while col_out[1] is driven.
  - Required: valid=1 with code=9 within the latency window.
  - With ready=1: valid drops the next cycle.
  - After release for 2 samples: col_out=4'b1111 and busy=0.
- Bounce: assert row_in for 1 sample during DEBOUNCE, then drop it -> no valid, return to IDLE, multi_err stays 0.
- Multi-key: row_in=4'b0011 on column 2 -> multi_err pulses 1 cycle, valid stays 0, state RELEASE until row_in=0 for 2 samples.
- Backpressure: ready=0 for 100 cycles after valid -> code and valid held stable, col_out=all-ones, a second key press ignored. Then ready=1 -> exactly one transfer.
- Reset during DEBOUNCE and again during REPORT with valid=1 -> valid=0, code=0, col_out=all-ones in the same cycle as reset assertion.
- ROWS=3, COLS=5 config: key at row 2, column 4 -> code=14 (CODE_W=4).

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared states and helpers for the keypad scanner
package keypad_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_SCAN     = 3'd1;
    localparam state_t ST_DEBOUNCE = 3'd2;
    localparam state_t ST_REPORT   = 3'd3;
    localparam state_t ST_RELEASE  = 3'd4;

    // Minimum width (at least 1) able to hold values 0..n-1.
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    // Row vectors are at most 8 wide, so callers zero-pad into 8 bits.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// rtl/keypad_scanner_row_sync.sv - two-flop synchroniser for the row sense lines
module row_sync
    import keypad_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad scanner with debounce and multi-key rejection
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 3,
    parameter int CODE_W   = clog2w(ROWS * COLS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_out,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ready,
    output logic              multi_err,
    output logic              busy
);

    localparam int DW = clog2w(SCAN_DIV);
    localparam int MW = clog2w(DEBOUNCE + 1);
    localparam int CW = clog2w(COLS);
    localparam int RW = clog2w(ROWS);

    logic [ROWS-1:0]   row_s;
    logic [ROWS-1:0]   row_lat;
    state_t            state;
    logic [DW-1:0]     dwell;
    logic [MW-1:0]     match;
    logic [CW-1:0]     col_idx;
    logic [RW-1:0]     row_idx;
    logic [RW-1:0]     row_hit;
    logic [RW-1:0]     row_sel;
    logic [7:0]        row_pad;
    logic [3:0]        row_cnt;
    logic [CODE_W-1:0] key_code;
    logic              sample;

    row_sync #(.W(ROWS)) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d     (row_in),
        .q     (row_s)
    );

    always_comb begin
        row_pad = '0;
        row_pad[ROWS-1:0] = row_s;
        row_cnt = popcount8(row_pad);
        row_hit = '0;
        for (int i = 0; i < ROWS; i++)
            if (row_s[i]) row_hit = RW'(i);
    end

    // With DEBOUNCE==1 the code is formed straight from the scan hit.
    assign row_sel  = (state == ST_SCAN) ? row_hit : row_idx;
    assign key_code = CODE_W'(row_sel) * CODE_W'(COLS) + CODE_W'(col_idx);
    assign sample   = (dwell == DW'(SCAN_DIV - 1));
    assign busy     = (state != ST_IDLE);

    always_comb begin
        col_out = '1;
        if (state == ST_SCAN || state == ST_DEBOUNCE)
            col_out = COLS'(1) << col_idx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            dwell     <= '0;
            match     <= '0;
            col_idx   <= '0;
            row_idx   <= '0;
            row_lat   <= '0;
            code      <= '0;
            valid     <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            multi_err <= 1'b0;
            if (state == ST_SCAN || state == ST_DEBOUNCE || state == ST_RELEASE)
                dwell <= sample ? '0 : dwell + DW'(1);
            case (state)
                ST_IDLE: begin
                    if (row_s != '0) begin
                        state   <= ST_SCAN;
                        col_idx <= '0;
                        dwell   <= '0;
                        match   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (sample) begin
                        if (row_cnt == 4'd0) begin
                            if (col_idx == CW'(COLS - 1)) state <= ST_IDLE;
                            else col_idx <= col_idx + CW'(1);
                        end else if (row_cnt == 4'd1) begin
                            row_idx <= row_hit;
                            row_lat <= row_s;
                            match   <= MW'(1);
                            if (DEBOUNCE == 1) begin
                                code  <= key_code;
                                valid <= 1'b1;
                                state <= ST_REPORT;
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end else begin
                            multi_err <= 1'b1;
                            match     <= '0;
                            state     <= ST_RELEASE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (sample) begin
                        if (row_s == row_lat) begin
                            if (match == MW'(DEBOUNCE - 1)) begin
                                code  <= key_code;
                                valid <= 1'b1;
                                state <= ST_REPORT;
                            end else begin
                                match <= match + MW'(1);
                            end
                        end else if (row_s == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            multi_err <= 1'b1;
                            match     <= '0;
                            state     <= ST_RELEASE;
                        end
                    end
                end
                ST_REPORT: begin
                    // Matrix is not scanned here, so a second key cannot slip in.
                    if (ready) begin
                        valid <= 1'b0;
                        dwell <= '0;
                        match <= '0;
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (sample) begin
                        if (row_s != '0) begin
                            match <= '0;
                        end else if (match == MW'(DEBOUNCE - 1)) begin
                            match <= '0;
                            state <= ST_IDLE;
                        end else begin
                            match <= match + MW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner in 4x4 and 3x5 configurations
module tb_keypad_scanner;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] row_in, col_out, code;
    logic       valid, ready, multi_err, busy;
    logic [2:0] row_in2;
    logic [4:0] col_out2;
    logic [3:0] code2;
    logic       valid2, ready2, multi_err2, busy2;

    logic       k_on [3];
    logic [1:0] k_r  [3];
    logic [1:0] k_c  [3];
    logic       key2_on;

    int total = 0, bad = 0, cyc = 0;
    int merr_cnt = 0, merr_wide = 0, merr_vr = 0, vrise = 0, xfer = 0;
    logic prev_merr = 1'b0, prev_valid = 1'b0;
    logic [3:0] sb_q [$];
    int  t0, lat, stable, m0, v0, x0;
    bit  ok;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clock(clock), .reset(reset), .row_in(row_in), .col_out(col_out), .code(code),
        .valid(valid), .ready(ready), .multi_err(multi_err), .busy(busy)
    );

    keypad_scanner #(.ROWS(3), .COLS(5), .SCAN_DIV(4), .DEBOUNCE(2)) dut2 (
        .clock(clock), .reset(reset), .row_in(row_in2), .col_out(col_out2), .code(code2),
        .valid(valid2), .ready(ready2), .multi_err(multi_err2), .busy(busy2)
    );

    // Key matrix: a pressed key shorts its column drive onto its row line.
    always_comb begin
        row_in = '0;
        for (int i = 0; i < 3; i++)
            if (k_on[i] && col_out[k_c[i]]) row_in[k_r[i]] = 1'b1;
    end
    assign row_in2 = (key2_on && col_out2[4]) ? 3'b100 : 3'b000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (multi_err) begin
            merr_cnt <= merr_cnt + 1;
            if (prev_merr) merr_wide <= merr_wide + 1;
        end
        if (valid && !prev_valid) begin
            vrise <= vrise + 1;
            if (multi_err) merr_vr <= merr_vr + 1;
        end
        prev_merr  <= multi_err;
        prev_valid <= valid;
        if (!reset && valid && ready) begin
            xfer <= xfer + 1;
            if (sb_q.size() == 0) chk("sb_unexpected", 32'(code), 32'hdead);
            else chk("sb_code", 32'(code), 32'(sb_q.pop_front()));
        end
    end

    task automatic press(input int s, input logic [1:0] r, input logic [1:0] c);
        k_r[s]  = r;
        k_c[s]  = c;
        k_on[s] = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_busy(input int limit, input logic level, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (busy == level) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1; ready = 1'b0; ready2 = 1'b0; key2_on = 1'b0;
        for (int i = 0; i < 3; i++) begin
            k_on[i] = 1'b0; k_r[i] = 2'd0; k_c[i] = 2'd0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_col_out", 32'(col_out), 32'hf);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_code", 32'(code), 0);
        chk("rst_multi_err", 32'(multi_err), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clock); #1 reset = 1'b0;
        repeat (3) @(posedge clock); #1;

        // Main press: row 2, column 1 -> code 9, immediate acceptance
        ready = 1'b1;
        sb_q.push_back(4'd9);
        t0 = cyc;
        press(0, 2'd2, 2'd1);
        wait_valid(60, ok);
        chk("main_valid_seen", 32'(ok), 1);
        lat = cyc - t0;
        chk("main_latency_window", 32'(lat >= 11 && lat <= 19), 1);
        @(negedge clock);
        chk("main_valid_drop", 32'(valid), 0);
        @(posedge clock); #1 k_on[0] = 1'b0;
        wait_busy(100, 1'b0, ok);
        chk("main_back_idle", 32'(ok), 1);
        chk("main_col_out_idle", 32'(col_out), 32'hf);

        // Bounce: key lost during debounce
        m0 = merr_cnt; v0 = vrise;
        @(posedge clock); #1 press(0, 2'd0, 2'd0);
        wait_busy(20, 1'b1, ok);
        chk("bounce_busy", 32'(ok), 1);
        repeat (4) @(posedge clock);
        #1 k_on[0] = 1'b0;
        wait_busy(40, 1'b0, ok);
        chk("bounce_idle", 32'(ok), 1);
        repeat (20) @(negedge clock);
        chk("bounce_no_valid", 32'(vrise), 32'(v0));
        chk("bounce_no_merr", 32'(merr_cnt), 32'(m0));

        // Multi-key on column 2
        m0 = merr_cnt; v0 = vrise;
        @(posedge clock); #1 press(0, 2'd0, 2'd2); press(1, 2'd1, 2'd2);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            if (multi_err) ok = 1'b1;
        end
        chk("multi_err_seen", 32'(ok), 1);
        repeat (20) @(negedge clock);
        chk("multi_err_once", 32'(merr_cnt), 32'(m0 + 1));
        chk("multi_err_width", 32'(merr_wide), 0);
        chk("multi_no_valid", 32'(vrise), 32'(v0));
        chk("multi_held_release", 32'(busy), 1);
        chk("multi_col_out", 32'(col_out), 32'hf);
        @(posedge clock); #1 k_on[0] = 1'b0; k_on[1] = 1'b0;
        wait_busy(60, 1'b0, ok);
        chk("multi_back_idle", 32'(ok), 1);

        // Backpressure with a second key pressed while valid pending
        @(posedge clock); #1 ready = 1'b0;
        x0 = xfer; v0 = vrise;
        sb_q.push_back(4'd15);
        press(0, 2'd3, 2'd3);
        wait_valid(100, ok);
        chk("bp_valid_seen", 32'(ok), 1);
        @(posedge clock); #1 k_on[0] = 1'b0; press(1, 2'd0, 2'd0);
        stable = 0;
        repeat (100) begin
            @(negedge clock);
            if (valid && code == 4'd15 && col_out == 4'hf) stable++;
        end
        chk("bp_held_stable", 32'(stable), 100);
        chk("bp_no_xfer_yet", 32'(xfer), 32'(x0));
        @(posedge clock); #1 ready = 1'b1;
        repeat (5) @(negedge clock);
        chk("bp_one_xfer", 32'(xfer), 32'(x0 + 1));
        chk("bp_valid_clear", 32'(valid), 0);
        @(posedge clock); #1 k_on[1] = 1'b0;
        wait_busy(60, 1'b0, ok);
        chk("bp_back_idle", 32'(ok), 1);
        repeat (60) @(negedge clock);
        chk("bp_second_ignored", 32'(vrise), 32'(v0 + 1));
        chk("bp_xfer_final", 32'(xfer), 32'(x0 + 1));

        // Reset asserted during debounce
        @(posedge clock); #1 press(0, 2'd0, 2'd0);
        wait_busy(20, 1'b1, ok);
        chk("rd_busy", 32'(ok), 1);
        repeat (6) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rd_valid", 32'(valid), 0);
        chk("rd_code", 32'(code), 0);
        chk("rd_col_out", 32'(col_out), 32'hf);
        chk("rd_busy_low", 32'(busy), 0);
        @(posedge clock); #1 k_on[0] = 1'b0;
        @(posedge clock); #1 reset = 1'b0;

        // Reset asserted during report with valid pending
        @(posedge clock); #1 ready = 1'b0; press(0, 2'd1, 2'd3);
        wait_valid(100, ok);
        chk("rr_valid_seen", 32'(ok), 1);
        chk("rr_code_before", 32'(code), 7);
        #2 reset = 1'b1;
        #1;
        chk("rr_valid", 32'(valid), 0);
        chk("rr_code", 32'(code), 0);
        chk("rr_col_out", 32'(col_out), 32'hf);
        @(posedge clock); #1 k_on[0] = 1'b0;
        @(posedge clock); #1 reset = 1'b0; ready = 1'b1;
        x0 = xfer;
        repeat (30) @(negedge clock);
        chk("rr_dropped", 32'(xfer), 32'(x0));

        // 3x5 configuration: row 2, column 4 -> code 14
        @(posedge clock); #1 ready2 = 1'b1; key2_on = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (valid2) ok = 1'b1;
        end
        chk("cfg2_valid_seen", 32'(ok), 1);
        chk("cfg2_code", 32'(code2), 14);
        @(negedge clock);
        chk("cfg2_valid_drop", 32'(valid2), 0);
        key2_on = 1'b0;

        repeat (5) @(negedge clock);
        chk("sb_empty", 32'(sb_q.size()), 0);
        chk("merr_with_valid_rise", 32'(merr_vr), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
